// File: rtl/mem_access.sv
// mem_access: memory pipeline stage that registers execute results and runs
// load/store transactions on a req/ack bus, producing register write-back.
module mem_access #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_in,
    input  logic [31:0] mem_instr_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_store_data_in,
    input  logic [4:0]  mem_write_addr_in,
    input  logic [31:0] mem_write_data_in,
    input  logic        mem_wen_in,
    output logic        mem_bus_req_out,
    output logic        mem_bus_we_out,
    output logic [31:0] mem_bus_addr_out,
    output logic [31:0] mem_bus_wdata_out,
    output logic [3:0]  mem_bus_wstrb_out,
    input  logic [31:0] mem_bus_rdata_in,
    input  logic        mem_bus_ack_in,
    output logic [4:0]  mem_write_addr_out,
    output logic [31:0] mem_write_data_out,
    output logic        mem_wen_out,
    output logic        mem_stall_out,
    output logic        mem_misalign_out,
    output logic        mem_bus_err_out
);
    typedef enum logic {IDLE, BUS} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d, addr_q, addr_d, wdata_q, wdata_d, wd_q, wd_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;
    logic [4:0]  rd_q, rd_d, wa_q, wa_d;
    logic        we_q, we_d, wen_q, wen_d, mis_q, mis_d, err_q, err_d;

    logic [6:0]  op;
    logic [2:0]  f3;
    logic [1:0]  sz;
    logic        is_ld, is_st, f3_ok, aligned, tmo;
    logic [31:0] st_data, sh, ld_data;
    logic [3:0]  strb;
    logic        unused_instr;

    assign op           = mem_instr_in[6:0];
    assign f3           = mem_instr_in[14:12];
    assign sz           = f3[1:0];
    assign unused_instr = ^{mem_instr_in[31:15], mem_instr_in[11:7]};
    assign is_ld        = op == 7'b0000011;
    assign is_st        = op == 7'b0100011;
    assign f3_ok        = is_ld ? (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) : (is_st && f3 <= 3'b010);
    assign aligned      = sz == 2'd2 ? mem_addr_in[1:0] == 2'b00 : sz == 2'd1 ? !mem_addr_in[0] : 1'b1;
    assign st_data      = sz == 2'd0 ? {4{mem_store_data_in[7:0]}} :
                          sz == 2'd1 ? {2{mem_store_data_in[15:0]}} : mem_store_data_in;
    assign strb         = !is_st ? 4'b0000 : sz == 2'd0 ? 4'b0001 << mem_addr_in[1:0] :
                          sz == 2'd1 ? (mem_addr_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    // func3[2] selects zero extension for LBU/LHU
    assign sh           = mem_bus_rdata_in >> {lane_q, 3'b000};
    assign ld_data      = f3_q[1] ? sh :
                          f3_q[0] ? {{16{!f3_q[2] & sh[15]}}, sh[15:0]} :
                                    {{24{!f3_q[2] & sh[7]}}, sh[7:0]};
    assign tmo          = BUS_TIMEOUT != 0 && cnt_q == 32'(BUS_TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        we_d    = we_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        rd_d    = rd_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        wen_d   = 1'b0;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (mem_valid_in) begin
                if (!(is_ld || is_st)) begin
                    wa_d  = mem_write_addr_in;
                    wd_d  = mem_write_data_in;
                    wen_d = mem_wen_in && mem_write_addr_in != 5'd0;
                end else if (f3_ok && !aligned) begin
                    mis_d = 1'b1;
                end else if (f3_ok) begin
                    state_d = BUS;
                    addr_d  = {mem_addr_in[31:2], 2'b00};
                    we_d    = is_st;
                    wdata_d = is_st ? st_data : 32'd0;
                    wstrb_d = strb;
                    f3_d    = f3;
                    lane_d  = mem_addr_in[1:0];
                    rd_d    = mem_write_addr_in;
                end
            end
        end else if (mem_bus_ack_in) begin
            state_d = IDLE;
            if (!we_q) begin
                wa_d  = rd_q;
                wd_d  = ld_data;
                wen_d = rd_q != 5'd0;
            end
        end else if (tmo) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            lane_q  <= '0;
            rd_q    <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            wen_q   <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
            rd_q    <= rd_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            wen_q   <= wen_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign mem_bus_req_out    = state_q == BUS;
    assign mem_stall_out      = state_q == BUS;
    assign mem_bus_we_out     = we_q;
    assign mem_bus_addr_out   = addr_q;
    assign mem_bus_wdata_out  = wdata_q;
    assign mem_bus_wstrb_out  = wstrb_q;
    assign mem_write_addr_out = wa_q;
    assign mem_write_data_out = wd_q;
    assign mem_wen_out        = wen_q;
    assign mem_misalign_out   = mis_q;
    assign mem_bus_err_out    = err_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed bench for mem_access; expected write-backs are queued
// when an instruction is issued and popped when the DUT pulses mem_wen_out.
module tb_mem_access;
    logic        clk = 1'b0, rst;
    logic        valid, wen_in, req, we, ack, wen_out, stall, mis, err;
    logic [31:0] instr, addr, sdata, wdata_in, baddr, bwdata, rdata, wdata_out;
    logic [4:0]  rd, wa_out;
    logic [3:0]  wstrb;
    int          checks = 0, failures = 0;
    logic [36:0] q[$];

    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011;

    mem_access #(.BUS_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_valid_in(valid), .mem_instr_in(instr),
        .mem_addr_in(addr), .mem_store_data_in(sdata), .mem_write_addr_in(rd),
        .mem_write_data_in(wdata_in), .mem_wen_in(wen_in),
        .mem_bus_req_out(req), .mem_bus_we_out(we), .mem_bus_addr_out(baddr),
        .mem_bus_wdata_out(bwdata), .mem_bus_wstrb_out(wstrb),
        .mem_bus_rdata_in(rdata), .mem_bus_ack_in(ack),
        .mem_write_addr_out(wa_out), .mem_write_data_out(wdata_out),
        .mem_wen_out(wen_out), .mem_stall_out(stall),
        .mem_misalign_out(mis), .mem_bus_err_out(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
        return {17'd0, f3, 5'd0, op};
    endfunction

    always @(negedge clk) begin
        if (!rst && wen_out) begin
            if (q.size() == 0) chk("wb_unexpected", 32'(wen_out), 32'd0);
            else begin
                logic [36:0] e;
                e = q.pop_front();
                chk("wb_addr", 32'(wa_out), 32'(e[36:32]));
                chk("wb_data", wdata_out, e[31:0]);
            end
        end
    end

    task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] s,
                         input logic [4:0] r, input logic [31:0] d, input logic w);
        valid = 1'b1; instr = i; addr = a; sdata = s; rd = r; wdata_in = d; wen_in = w;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [4:0] r, input int waits, input logic [31:0] rd_word,
                        input logic [31:0] exp);
        if (r != 5'd0) q.push_back({r, exp});
        issue(mk(f3, LD), a, 32'd0, r, 32'd0, 1'b0);
        chk({tag, "_addr"}, baddr, {a[31:2], 2'b00});
        chk({tag, "_we"}, 32'(we), 32'd0);
        chk({tag, "_strb"}, 32'(wstrb), 32'd0);
        for (int k = 0; k < waits; k++) begin
            chk({tag, "_stall"}, 32'(stall), 32'd1);
            @(negedge clk);
        end
        chk({tag, "_req"}, 32'(req), 32'd1);
        ack = 1'b1; rdata = rd_word;
        @(negedge clk);
        ack = 1'b0; rdata = 32'hDEADDEAD;
        chk({tag, "_req_drop"}, 32'(req), 32'd0);
        chk({tag, "_wen"}, 32'(wen_out), 32'(r != 5'd0));
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; instr = '0; addr = '0; sdata = '0; rd = '0;
        wdata_in = '0; wen_in = 1'b0; ack = 1'b0; rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wen", 32'(wen_out), 32'd0);
        chk("rst_flags", {30'd0, mis, err}, 32'd0);
        chk("rst_bus", baddr | bwdata | 32'(wstrb), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        q.push_back({5'd5, 32'h1234});
        issue(32'h00000033, 32'd0, 32'd0, 5'd5, 32'h1234, 1'b1);
        chk("pt_wen", 32'(wen_out), 32'd1);
        chk("pt_stall", 32'(stall), 32'd0);
        @(negedge clk);
        chk("pt_wen_pulse", 32'(wen_out), 32'd0);

        load("lb", 3'b000, 32'h103, 5'd7, 3, 32'h80AABBCC, 32'hFFFFFF80);
        load("lbu", 3'b100, 32'h103, 5'd7, 3, 32'h80AABBCC, 32'h00000080);
        load("lh", 3'b001, 32'h102, 5'd8, 1, 32'h80AABBCC, 32'hFFFF80AA);
        load("lhu", 3'b101, 32'h100, 5'd8, 0, 32'h80AABBCC, 32'h0000BBCC);
        load("lw", 3'b010, 32'h104, 5'd9, 0, 32'h13579BDF, 32'h13579BDF);
        load("lw_rd0", 3'b010, 32'h108, 5'd0, 0, 32'h11111111, 32'h0);

        q.push_back({5'd3, 32'h55});
        issue(32'h00000013, 32'd0, 32'd0, 5'd3, 32'h55, 1'b1);
        chk("b2b_wen", 32'(wen_out), 32'd1);

        issue(mk(3'b001, ST), 32'h202, 32'h0000BEEF, 5'd0, 32'd0, 1'b0);
        chk("sh_req", 32'(req), 32'd1);
        chk("sh_we", 32'(we), 32'd1);
        chk("sh_addr", baddr, 32'h200);
        chk("sh_strb", 32'(wstrb), 32'hC);
        chk("sh_wdata", bwdata, 32'hBEEFBEEF);
        @(negedge clk);
        chk("sh_wdata_hold", bwdata, 32'hBEEFBEEF);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("sh_req_drop", 32'(req), 32'd0);
        chk("sh_no_wen", 32'(wen_out), 32'd0);

        issue(mk(3'b000, ST), 32'h203, 32'h000000A5, 5'd0, 32'd0, 1'b0);
        chk("sb_strb", 32'(wstrb), 32'h8);
        chk("sb_wdata", bwdata, 32'hA5A5A5A5);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        issue(mk(3'b010, LD), 32'h301, 32'd0, 5'd4, 32'd0, 1'b0);
        chk("mis_req", 32'(req), 32'd0);
        chk("mis_pulse", 32'(mis), 32'd1);
        chk("mis_wen", 32'(wen_out), 32'd0);
        @(negedge clk);
        chk("mis_pulse_end", 32'(mis), 32'd0);
        chk("mis_req_never", 32'(req), 32'd0);

        issue(mk(3'b011, LD), 32'h300, 32'd0, 5'd4, 32'd0, 1'b0);
        chk("badf3_req", 32'(req), 32'd0);
        chk("badf3_flags", {30'd0, mis, err}, 32'd0);

        issue(mk(3'b010, LD), 32'h400, 32'd0, 5'd9, 32'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("to_req", 32'(req), 32'd1);
            @(negedge clk);
        end
        chk("to_req_drop", 32'(req), 32'd0);
        chk("to_err", 32'(err), 32'd1);
        chk("to_stall", 32'(stall), 32'd0);
        chk("to_wen", 32'(wen_out), 32'd0);
        @(negedge clk);
        chk("to_err_end", 32'(err), 32'd0);

        load("ack_on_to", 3'b010, 32'h404, 5'd10, 3, 32'h11223344, 32'h11223344);
        chk("ack_on_to_err", 32'(err), 32'd0);

        issue(mk(3'b010, LD), 32'h500, 32'd0, 5'd11, 32'd0, 1'b0);
        chk("ar_req_pre", 32'(req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_req", 32'(req), 32'd0);
        chk("ar_stall", 32'(stall), 32'd0);
        chk("ar_wen", 32'(wen_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load("post_rst", 3'b010, 32'h0, 5'd12, 0, 32'hCAFEF00D, 32'hCAFEF00D);
        @(negedge clk);
        chk("sb_empty", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers execute results and performs load/store transactions on a req/ack data bus.
- Stalls the upstream pipeline while a transaction is outstanding.
- Produces the final register write-back (addr/data/wen) for the register file.

Parameters:
BUS_TIMEOUT, 255, max cycles to wait for mem_bus_ack_in before aborting; 0 disables timeout.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
mem_valid_in  in  1  execute-stage result valid this cycle
mem_instr_in  in  32  instruction word (opcode [6:0], func3 [14:12])
mem_addr_in  in  32  load/store effective address computed by execute stage
mem_store_data_in  in  32  rs2 value for stores
mem_write_addr_in  in  5  rd from execute stage
mem_write_data_in  in  32  execute-stage result for non-memory instructions
mem_wen_in  in  1  execute-stage write enable
mem_bus_req_out  out  1  bus request
mem_bus_we_out  out  1  1 = write, 0 = read
mem_bus_addr_out  out  32  word-aligned bus address ({addr[31:2],2'b00})
mem_bus_wdata_out  out  32  store data, lane-replicated
mem_bus_wstrb_out  out  4  byte strobes
mem_bus_rdata_in  in  32  read data, valid with ack
mem_bus_ack_in  in  1  transaction complete
mem_write_addr_out  out  5  write-back rd
mem_write_data_out  out  32  write-back data
mem_wen_out  out  1  write-back enable (single-cycle pulse per instruction)
mem_stall_out  out  1  hold upstream stages
mem_misalign_out  out  1  one-cycle pulse: misaligned access dropped
mem_bus_err_out  out  1  one-cycle pulse: bus timeout abort

Behaviour:
- Reset: every output is 0, FSM = IDLE, timeout counter = 0. Reset asserted mid-transaction drops req immediately (async); no write-back occurs for that instruction.
- FSM states: IDLE, BUS.
- Accept: in IDLE, when mem_valid_in=1. mem_stall_out = (state==BUS). Upstream holds its inputs while stall is high; inputs are ignored in BUS.
- Non-memory opcode: write addr/data/wen registered straight through. 1-cycle latency. FSM stays IDLE.
- LOAD (7'b0000011): func3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- STORE (7'b0100011): func3 000 SB, 001 SH, 010 SW.
- Any other load/store func3: no bus access, no write-back, no error flag.
- Alignment check at accept: H requires addr[0]=0; W requires addr[1:0]=0.
  - Misaligned: no request, mem_misalign_out=1 for the next cycle, wen_out=0, FSM stays IDLE.
- Aligned access:
  - Next cycle the FSM enters BUS and req=1 with addr/we/wdata/wstrb registered.
  - All bus outputs stay stable until an ack is sampled at a rising edge with req=1.
- Strobes and write data:
  - SB: wstrb = 4'b0001<<addr[1:0], wdata = {4{byte}}.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{half}}.
  - SW: wstrb = 4'b1111. Reads: wstrb = 0.
- On ack edge: req drops, FSM returns to IDLE, stall deasserts.
  - Load: the lane selected by addr[1:0] is extracted from rdata, sign-extended (LB/LH) or zero-extended (LBU/LHU).
  - Load write-back: mem_write_data_out/addr valid with wen_out=1 in the cycle after the ack edge.
  - Store: no write-back.
- Load latency: accept edge N, req in N+1. Ack sampled at edge M gives write-back during cycle M+1. Minimum 2 cycles from accept to write-back.
- Timeout: counter increments each cycle in BUS. On reaching BUS_TIMEOUT without ack: req drops, FSM goes IDLE, mem_bus_err_out pulses 1 cycle, no write-back. An ack arriving on the timeout edge takes priority over the timeout.
- rd=0: wen_out forced to 0 (load still performed).
- wen_out is 0 in every cycle that does not complete an instruction. A new instruction may be accepted in the same cycle as a load write-back.

Test Plan:
- Non-memory pass-through: valid with rd=5, data=0x1234, wen=1 -> next cycle wen_out=1, addr_out=5, data_out=0x1234, stall=0.
- LB sign-extension: LB addr=0x103, ack after 3 cycles with rdata=0x80AABBCC -> stall held high throughout; write-back data 0xFFFFFF80, bus_addr=0x100. Repeat as LBU -> 0x00000080.
- SH upper half: SH addr=0x202, store_data=0x0000BEEF -> req, we=1, wstrb=1100, wdata=0xBEEFBEEF; no wen_out after ack.
- Misaligned LW: LW addr=0x301 -> req never asserted, misalign pulse 1 cycle, wen_out=0.
- Timeout: BUS_TIMEOUT=4, no ack -> req drops after 4 cycles in BUS, bus_err pulse, stall released. Repeat with ack on the 4th edge -> load completes, no err pulse.
- Async reset: assert rst while req=1 -> req/stall/wen drop immediately. After release, a LW addr=0x0 with immediate ack completes normally.
